argmax_seq_ctrl: RTL and testbench

- Sequential argmax controller for the classifier output stage.
- Accepts N class scores one per beat from the final fully-connected layer over a valid/ready stream.
- Keeps a running maximum and presents the winning class index and its score through a held output handshake.
- Replaces the wide N*WIDTH combinational compare tree when scores arrive serially from the shared MAC array.

---
 rtl/argmax_seq_ctrl.sv | 109 ++++++++++
 tb/tb_argmax_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq_ctrl.sv
// argmax_seq_ctrl
//   Sequential argmax over N signed class scores. The scores arrive one per
//   beat on a valid/ready stream, and beat k carries class k. A running maximum
//   is kept. When the last beat has been taken, the winning index and its
//   score are presented and held until the downstream accepts them.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a new inference (only looked at in IDLE)
//   busy       high while accumulating or holding a result
//   in_valid   score beat valid
//   in_ready   controller can accept a score (ACCUM only)
//   in_data    signed class score
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   max_index  index of the maximum score (registered)
//   max_value  maximum score, signed (registered)
module argmax_seq_ctrl #(
   parameter int N     = 4,
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(N)-1:0]  max_index,
   output logic [WIDTH-1:0]      max_value
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [IW-1:0]    count_reg;
   logic [IW-1:0]    max_index_reg;
   logic [WIDTH-1:0] max_value_reg;
   logic             accept;
   logic             take_beat;

   // Next state and handshake outputs. All of these depend only on the state
   // register and the control inputs. No path runs from in_data to an output.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            accept   = in_valid;
            if (in_valid && (count_reg == LAST)) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The first beat always loads. A later beat replaces the maximum only when
   // it is strictly greater. Equal scores keep the earlier, lower index.
   assign take_beat = (count_reg == '0) ||
                      ($signed(in_data) > $signed(max_value_reg));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         max_index_reg <= '0;
         max_value_reg <= '0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == IDLE) && start) begin
            count_reg     <= '0;
            max_index_reg <= '0;
            max_value_reg <= '0;
         end else if (accept) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + IW'(1);
            if (take_beat) begin
               max_index_reg <= count_reg;
               max_value_reg <= in_data;
            end
         end
      end
   end

   assign max_index = max_index_reg;
   assign max_value = max_value_reg;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Testbench for argmax_seq_ctrl (N=4, WIDTH=16).
// A table of directed vectors runs first. Hand sequences for reset and the
// control corner cases follow, then randomized inferences checked against a
// plain-arithmetic argmax model.
module tb_argmax_seq_ctrl;

   localparam int N = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    max_index;
   logic [W-1:0]  max_value;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   argmax_seq_ctrl #(.N(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .max_index (max_index),
      .max_value (max_value)
   );

   typedef struct {
      logic [3:0][W-1:0] sc;
      int                gap_at;    // insert idle cycles before this beat (-1 none)
      int                gap_len;
      int                hold;      // cycles with out_ready low in DONE
      bit                start_mid; // keep start high through ACCUM/DONE/handshake
      int                exp_idx;
      logic [W-1:0]      exp_val;
   } vec_t;

   function automatic vec_t mk(input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input logic [W-1:0] s2, input logic [W-1:0] s3,
                               input int gap_at, input int gap_len, input int hold,
                               input bit start_mid, input int ei, input logic [W-1:0] ev);
      vec_t v;
      v.sc[0] = s0; v.sc[1] = s1; v.sc[2] = s2; v.sc[3] = s3;
      v.gap_at = gap_at; v.gap_len = gap_len; v.hold = hold;
      v.start_mid = start_mid; v.exp_idx = ei; v.exp_val = ev;
      return v;
   endfunction

   // Reference: first index holding the largest signed score.
   function automatic int model_idx(input logic [3:0][W-1:0] sc);
      int best = 0;
      for (int k = 1; k < N; k++)
         if (int'($signed(sc[k])) > int'($signed(sc[best]))) best = k;
      return best;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_result(input string tag, input vec_t v);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_index"},     32'(max_index), 32'(v.exp_idx));
      chk({tag, "_value"},     32'(max_value), 32'(v.exp_val));
   endtask

   // Entered and left at a falling edge with the DUT in IDLE.
   task automatic run_vec(input int id, input vec_t v);
      start = 1'b1;
      @(negedge clk);
      start = v.start_mid;
      chk("busy_accum", 32'(busy), 32'd1);
      for (int k = 0; k < N; k++) begin
         if (k == v.gap_at) begin
            in_valid = 1'b0;
            repeat (v.gap_len) begin
               @(negedge clk);
               chk("ready_in_gap", 32'(in_ready), 32'd1);
            end
         end
         chk("ready_beat", 32'(in_ready), 32'd1);
         chk("no_early_out", 32'(out_valid), 32'd0);
         in_valid = 1'b1;
         in_data  = v.sc[k];
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 16'hdead;
      end
      for (int h = 0; h < v.hold; h++) begin
         chk_result("hold", v);
         @(negedge clk);
      end
      chk_result("result", v);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      $display("vec %0d: scores %h %h %h %h -> idx %0d val %h (expect %0d %h)",
               id, v.sc[0], v.sc[1], v.sc[2], v.sc[3], max_index, max_value,
               v.exp_idx, v.exp_val);
   endtask

   vec_t tbl[8];
   vec_t rv;

   initial begin
      tbl[0] = mk(16'd7,    16'd5,    16'd20,   16'd10,  -1, 0, 0, 1'b0, 2, 16'd20);
      tbl[1] = mk(16'd30,   16'd25,   16'd50,   16'd1,    2, 2, 0, 1'b0, 2, 16'd50);
      tbl[2] = mk(16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF8, -1, 0, 0, 1'b0, 1, 16'hFFFD);
      tbl[3] = mk(16'd90,   16'd80,   16'd20,   16'd100, -1, 0, 5, 1'b0, 3, 16'd100);
      tbl[4] = mk(16'd9,    16'd9,    16'd9,    16'd9,   -1, 0, 0, 1'b0, 0, 16'd9);
      tbl[5] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 1, 1, 1'b0, 0, 16'h8000);
      tbl[6] = mk(16'h8000, 16'h7FFF, 16'h8000, 16'd0,   -1, 0, 0, 1'b0, 1, 16'h7FFF);
      tbl[7] = mk(16'd3,    16'd40,   16'd12,   16'd40,   3, 1, 2, 1'b1, 1, 16'd40);

      // Reset state
      #2;
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_index",     32'(max_index), 32'd0);
      chk("rst_value",     32'(max_value), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed table, back to back
      for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      in_data  = 16'h7000;
      repeat (2) begin
         @(negedge clk);
         chk("idle_valid_ready", 32'(in_ready), 32'd0);
         chk("idle_valid_busy",  32'(busy),     32'd0);
      end
      in_valid = 1'b0;
      $display("seq idle_valid: busy %0b in_ready %0b", busy, in_ready);

      // Async reset after two of four beats
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_data  = 16'd500;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",     32'(busy),      32'd0);
      chk("arst_in_ready", 32'(in_ready),  32'd0);
      chk("arst_index",    32'(max_index), 32'd0);
      chk("arst_value",    32'(max_value), 32'd0);
      $display("seq async_reset: busy %0b idx %0d val %h", busy, max_index, max_value);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(100, mk(16'd1, 16'd2, 16'd3, 16'd4, -1, 0, 0, 1'b0, 3, 16'd4));

      // Randomized inferences against the model
      for (int r = 0; r < 150; r++) begin
         for (int k = 0; k < N; k++)
            rv.sc[k] = (r % 2 == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
         rv.gap_at    = $urandom_range(0, 4) - 1;
         rv.gap_len   = $urandom_range(0, 2);
         rv.hold      = $urandom_range(0, 2);
         rv.start_mid = 1'($urandom_range(0, 1));
         rv.exp_idx   = model_idx(rv.sc);
         rv.exp_val   = rv.sc[rv.exp_idx];
         run_vec(200 + r, rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
